// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction memory geometry, halt word, loader FSM encodings.
// The decode stage uses HALT_WORD for halt detection; the loader uses it for padding.
package cpu_pkg;

  localparam int IMEM_DEPTH  = 512;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 32;

  localparam logic [IMEM_DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] LDR_IDLE = 2'd0;
  localparam logic [1:0] LDR_LOAD = 2'd1;
  localparam logic [1:0] LDR_PAD  = 2'd2;
  localparam logic [1:0] LDR_DONE = 2'd3;

  function automatic logic is_halt(input logic [IMEM_DATA_W-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Program word stream plus instruction RAM write port.
// master = host/bench side, slave = loader side.
interface imem_loader_if import cpu_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: streams program words into instruction RAM from address 0, pads the rest with HALT_WORD.
// RAM write is combinational from the handshake (0 cycles); s_ready drops outside LOAD or once the RAM is full.
module imem_loader import cpu_pkg::*; #(
  parameter int                DEPTH     = IMEM_DEPTH,
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_run,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] PTR_END  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]      state, state_nxt;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] wc;
  logic            ovf;
  logic            done_q;

  logic full, xfer, pad_wr, start_ok, drop;

  assign full     = (ptr == PTR_END);
  assign xfer     = (state == LDR_LOAD) && bus.s_valid && !full;
  assign pad_wr   = (state == LDR_PAD);
  assign start_ok = start && ((state == LDR_IDLE) || (state == LDR_DONE));
  // A word offered after the RAM is full ends the load with overflow and is never written.
  assign drop     = (state == LDR_LOAD) && bus.s_valid && full;

  always_comb begin
    state_nxt = state;
    case (state)
      LDR_IDLE: if (start_ok) state_nxt = LDR_LOAD;
      LDR_LOAD: begin
        if (xfer && bus.s_last) state_nxt = (ptr == PTR_LAST) ? LDR_DONE : LDR_PAD;
        else if (drop)          state_nxt = LDR_DONE;
      end
      LDR_PAD:  if (ptr == PTR_LAST) state_nxt = LDR_DONE;
      LDR_DONE: if (start_ok) state_nxt = LDR_LOAD;
      default:  state_nxt = LDR_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= LDR_IDLE;
      ptr    <= '0;
      wc     <= '0;
      ovf    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == LDR_DONE) && (state != LDR_DONE);
      if (start_ok) begin
        ptr <= '0;
        wc  <= '0;
        ovf <= 1'b0;
      end else begin
        if (xfer || pad_wr) ptr <= ptr + 1'b1;
        if (xfer)           wc  <= wc + 1'b1;
        if (drop)           ovf <= 1'b1;
      end
    end
  end

  assign bus.s_ready   = (state == LDR_LOAD) && !full;
  assign bus.ram_we    = xfer || pad_wr;
  assign bus.ram_addr  = ptr[ADDR_W-1:0];
  assign bus.ram_wdata = pad_wr ? HALT_WORD : (xfer ? bus.s_data : '0);

  assign cpu_run    = (state == LDR_DONE);
  assign done       = done_q;
  assign overflow   = ovf;
  assign word_count = wc;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a RAM model captures writes and the directed scenarios check image contents and flags.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start;
  logic        cpu_run, done, overflow;
  logic [9:0]  word_count;

  imem_loader_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  imem_loader dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .bus        (bus.slave),
    .cpu_run    (cpu_run),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem [512];
  int pad_cnt  = 0;
  int done_cnt = 0;
  int hs_err   = 0;
  int bad_wr   = 0;
  int addr_q [$];

  always @(posedge CLK) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_we && !bus.s_ready) pad_cnt++;
    if (bus.s_ready && (bus.ram_we != bus.s_valid)) hs_err++;
    if (bus.ram_we && bus.s_ready) addr_q.push_back(int'(bus.ram_addr));
    if (bus.ram_we && bus.ram_wdata == 32'hB000_0200) bad_wr++;
  end

  always @(negedge CLK) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Offer one word at a negedge and hold it until the handshake edge has passed.
  task automatic push(input logic [31:0] d, input logic l);
    bit ok = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    for (int t = 0; t < 50; t++) begin
      if (bus.s_ready) begin
        ok = 1;
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!ok) chk("push_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_run(input string tag, input int budget);
    for (int i = 0; i < budget && !cpu_run; i++) @(negedge CLK);
    chk(tag, 64'(cpu_run), 64'd1);
  endtask

  task automatic chk_halt_from(input string tag, input int lo);
    int bad = 0;
    for (int a = lo; a < 512; a++) if (mem[a] !== HALT) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  int pad0, dc0;

  initial begin
    RST_N = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_outputs", {bus.s_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                        cpu_run, done, overflow, word_count}, 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Three-word program
    pad0 = pad_cnt; dc0 = done_cnt;
    pulse_start();
    push(32'h2001_0005, 1'b0);
    push(32'h2002_0003, 1'b0);
    push(32'h0022_1820, 1'b1);
    wait_run("prog3_run", 600);
    repeat (3) @(negedge CLK);
    chk("prog3_w0", mem[0], 32'h2001_0005);
    chk("prog3_w1", mem[1], 32'h2002_0003);
    chk("prog3_w2", mem[2], 32'h0022_1820);
    chk_halt_from("prog3_pad", 3);
    chk("prog3_padcyc", 64'(pad_cnt - pad0), 64'd509);
    chk("prog3_wc", word_count, 64'd3);
    chk("prog3_done", 64'(done_cnt - dc0), 64'd1);
    chk("prog3_done_low", done, 64'd0);

    // Reload from DONE with one word
    pulse_start();
    chk("reload_run_fall", cpu_run, 64'd0);
    chk("reload_wc_clear", word_count, 64'd0);
    push(32'h1234_5678, 1'b1);
    wait_run("reload_run", 600);
    chk("reload_w0", mem[0], 32'h1234_5678);
    chk_halt_from("reload_pad", 1);
    chk("reload_wc", word_count, 64'd1);

    // Backpressure and gaps
    pulse_start();
    addr_q.delete();
    hs_err = 0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      push(32'h5000_0000 + 32'(i), i == 9);
    end
    wait_run("gap_run", 600);
    chk("gap_hs", 64'(hs_err), 64'd0);
    chk("gap_nwr", 64'(addr_q.size()), 64'd10);
    begin
      int bad = 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad++;
      chk("gap_addr_seq", 64'(bad), 64'd0);
    end
    chk("gap_w9", mem[9], 32'h5000_0009);
    chk("gap_pad10", mem[10], HALT);

    // Full image: last word lands at DEPTH-1
    pulse_start();
    pad0 = pad_cnt;
    for (int i = 0; i < 512; i++) push(32'hA000_0000 + 32'(i), i == 511);
    chk("full_direct_done", cpu_run, 64'd1);
    chk("full_nopad", 64'(pad_cnt - pad0), 64'd0);
    chk("full_ovf", overflow, 64'd0);
    chk("full_wc", word_count, 64'd512);
    chk("full_w0", mem[0], 32'hA000_0000);
    chk("full_w511", mem[511], 32'hA000_01FF);

    // Overflow: 513 words, no last
    pulse_start();
    bad_wr = 0;
    for (int i = 0; i < 512; i++) push(32'hB000_0000 + 32'(i), 1'b0);
    chk("ovf_ready_low", bus.s_ready, 64'd0);
    chk("ovf_not_done_yet", cpu_run, 64'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hB000_0200;
    @(negedge CLK);
    bus.s_valid = 1'b0;
    chk("ovf_flag", overflow, 64'd1);
    chk("ovf_run", cpu_run, 64'd1);
    chk("ovf_wc", word_count, 64'd512);
    chk("ovf_w511", mem[511], 32'hB000_01FF);
    chk("ovf_w512_unwritten", 64'(bad_wr), 64'd0);

    // Reset in the middle of a load
    pulse_start();
    chk("mid_ovf_clear", overflow, 64'd0);
    for (int i = 0; i < 100; i++) push(32'hC000_0000 + 32'(i), 1'b0);
    chk("mid_wc100", word_count, 64'd100);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC000_0064;
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_ready", bus.s_ready, 64'd0);
    chk("mid_rst_outputs", {bus.s_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                            cpu_run, done, overflow, word_count}, 64'd0);
    bus.s_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    pulse_start();
    addr_q.delete();
    push(32'hD000_0001, 1'b1);
    chk("mid_reload_nwr", 64'(addr_q.size()), 64'd1);
    if (addr_q.size() > 0) chk("mid_reload_addr0", 64'(addr_q[0]), 64'd0);
    wait_run("mid_reload_run", 600);
    chk("mid_reload_w0", mem[0], 32'hD000_0001);
    chk("mid_reload_w99", mem[99], HALT);
    chk("mid_reload_wc", word_count, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction loader upstream of the CPU's instruction RAM.
- Accepts 32-bit machine-code words on a valid/ready stream and writes them to consecutive instruction RAM addresses starting at 0.
- Fills every remaining address with the halt word, then releases the CPU to run.
- Replaces behavioural file preloading: the same program image can be streamed in by a bench or a host interface.

Parameters:
- DEPTH, 512: instruction RAM depth in words.
- ADDR_W, 9: RAM address width; must satisfy 2**ADDR_W == DEPTH.
- DATA_W, 32: instruction word width.
- HALT_WORD, 32'hFFFF_FFFF: end-of-program word used for padding.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored unless state is IDLE or DONE.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_W  instruction word.
- s_last  in  1  marks the final word of the program; qualified by s_valid.
- ram_we  out  1  instruction RAM write enable.
- ram_addr  out  ADDR_W  instruction RAM write address.
- ram_wdata  out  DATA_W  instruction RAM write data.
- cpu_run  out  1  high only in DONE; gates the CPU's reset and fetch.
- done  out  1  one-cycle pulse on entry to DONE.
- overflow  out  1  sticky flag; set when the stream supplies more than DEPTH words.
- word_count  out  ADDR_W+1  number of program words accepted in the current load.

Behaviour:
- Reset, asynchronous on RST_N low:
  - State goes to IDLE.
  - All outputs are 0, including ram_addr, ram_wdata and word_count.
  - Reset asserted mid-load aborts the load immediately. cpu_run drops in the same instant. The RAM keeps a partial image; this is acceptable.
- FSM states: IDLE, LOAD, PAD, DONE.
- IDLE:
  - s_ready=0, ram_we=0.
  - start moves to LOAD, clears the address pointer, word_count and overflow.
- LOAD:
  - s_ready=1 while the pointer is below DEPTH.
  - Handshake: a transfer occurs in any cycle with s_valid && s_ready. s_data must be held until that cycle.
  - On each transfer, in the same cycle:
    - ram_we=1, ram_addr=pointer, ram_wdata=s_data. The RAM write is combinational from the handshake, so write latency is 0 cycles.
    - The pointer and word_count increment at the edge.
  - Transfer with s_last=1:
    - If the pointer after increment is below DEPTH, go to PAD.
    - If the last word lands at address DEPTH-1, skip PAD and go directly to DONE.
  - Pointer reaches DEPTH without s_last:
    - s_ready drops to 0.
    - The FSM stays in LOAD and the words that follow are not accepted.
    - If s_valid is still high the cycle after the pointer reaches DEPTH, set overflow and go to DONE. The unaccepted word is dropped and no RAM write occurs.
  - s_valid=0 stalls with no write. There is no timeout.
- PAD:
  - s_ready=0.
  - Each cycle writes ram_we=1, ram_addr=pointer, ram_wdata=HALT_WORD, then increments the pointer.
  - Moves to DONE after writing address DEPTH-1.
  - Pad length is exactly DEPTH - word_count cycles.
- DONE:
  - cpu_run=1, s_ready=0, ram_we=0.
  - done pulses for the single cycle after the transition.
  - word_count and overflow hold their values.
  - start returns to LOAD and reloads: cpu_run falls and the counters clear at that edge.
- Empty program: there is no zero-length path. The first accepted word always exists. A stream of only the halt word is legal.
- Simultaneous events:
  - start in LOAD or PAD is ignored.
  - s_valid in IDLE, PAD or DONE is ignored; no write occurs.
- Width rules:
  - The pointer is ADDR_W+1 bits wide, so DEPTH is representable.
  - ram_addr is the pointer's low ADDR_W bits.

Decomposition:
- Shared package cpu_pkg:
  - state enum LDR_IDLE/LDR_LOAD/LDR_PAD/LDR_DONE;
  - HALT_WORD constant, shared with the decode stage's halt detection;
  - IMEM_DEPTH and IMEM_ADDR_W.
- Single module; no sub-module required.
- The address pointer/counter can optionally be factored as ldr_addr_ctr, but inline is preferred.

Test Plan:
- Three-word program: start, stream 0x20010005, 0x20020003, 0x00221820 (last). Required:
  - RAM[0..2] hold these words and RAM[3..511] = 0xFFFFFFFF;
  - exactly 509 PAD cycles, word_count=3, one done pulse, then cpu_run=1.
- Backpressure and gaps: toggle s_valid randomly while streaming 10 words. Required:
  - a write occurs only on handshake cycles;
  - addresses are consecutive 0..9 with no duplicates.
- Full image: stream 512 words with s_last on the 512th. Required: no PAD state, direct transition to DONE, overflow=0, word_count=512.
- Overflow: stream 513 words with no s_last. Required:
  - s_ready low after 512 writes, overflow=1, DONE reached;
  - RAM[511] holds word 511 and word 512 is never written.
- Reset mid-load: pull RST_N low after 100 words. Required:
  - all outputs go to 0 immediately and the state is IDLE;
  - a subsequent start reloads from address 0.
- Reload from DONE: after the first scenario, start again and stream 1 word. Required:
  - cpu_run falls at start;
  - RAM[0] is updated and RAM[1..511] = HALT_WORD;
  - word_count=1.
